// File: rtl/muldiv_pkg.sv
// muldiv_pkg: shared widths, op encodings, FSM states and helpers for muldiv_seq
//   XLEN  operand and HI/LO width
//   ITER  radix-2 steps per operation
//   CW    iteration counter width
package muldiv_pkg;
   localparam int XLEN = 32;
   localparam int ITER = XLEN;
   localparam int CW = $clog2(ITER);
   typedef enum logic [1:0] {OP_MULT = 2'b00, OP_MULTU = 2'b01, OP_DIV = 2'b10, OP_DIVU = 2'b11} op_t;
   typedef enum logic [1:0] {S_IDLE, S_RUN, S_FIX} state_t;
   function automatic logic [XLEN-1:0] mag(input logic [XLEN-1:0] x);
      return x[XLEN-1] ? -x : x;
   endfunction
endpackage

// File: rtl/muldiv_seq_if.sv
// muldiv_seq_if: command/result bundle between the core and the HI/LO sequencer
//   start, op, op_a, op_b    launch request and operands (master -> slave)
//   mthi, mtlo, wr_data      direct HI/LO writes (master -> slave)
//   hi, lo                   architectural HI/LO (slave -> master)
//   busy, done, div_zero     status (slave -> master)
interface muldiv_seq_if;
   import muldiv_pkg::*;
   logic start;
   op_t op;
   logic [XLEN-1:0] op_a;
   logic [XLEN-1:0] op_b;
   logic mthi;
   logic mtlo;
   logic [XLEN-1:0] wr_data;
   logic [XLEN-1:0] hi;
   logic [XLEN-1:0] lo;
   logic busy;
   logic done;
   logic div_zero;
   modport master (output start, op, op_a, op_b, mthi, mtlo, wr_data, input hi, lo, busy, done, div_zero);
   modport slave (input start, op, op_a, op_b, mthi, mtlo, wr_data, output hi, lo, busy, done, div_zero);
endinterface

// File: rtl/muldiv_step.sv
// muldiv_step: one combinational radix-2 multiply or restoring-divide iteration
//   acc_hi, acc_lo  current accumulator halves
//   b               magnitude of multiplier / divisor
//   div             1 = divide step, 0 = multiply step
//   nx_hi, nx_lo    accumulator after this step
module muldiv_step
   import muldiv_pkg::*;
(
   input  logic [XLEN-1:0] acc_hi,
   input  logic [XLEN-1:0] acc_lo,
   input  logic [XLEN-1:0] b,
   input  logic            div,
   output logic [XLEN-1:0] nx_hi,
   output logic [XLEN-1:0] nx_lo
);
   logic [XLEN:0] sum, rem, diff;
   always_comb begin
      // multiply: add b when the current multiplier bit is set, then shift the pair right
      sum = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, b} : '0);
      // divide: shift the next dividend bit into the remainder; diff sign bit is the borrow
      rem = {acc_hi, acc_lo[XLEN-1]};
      diff = rem - {1'b0, b};
      nx_hi = div ? (diff[XLEN] ? rem[XLEN-1:0] : diff[XLEN-1:0]) : sum[XLEN:1];
      nx_lo = div ? {acc_lo[XLEN-2:0], ~diff[XLEN]} : {sum[0], acc_lo[XLEN-1:1]};
   end
endmodule

// File: rtl/muldiv_seq.sv
// muldiv_seq: iterative MULT/MULTU/DIV/DIVU sequencer owning the HI/LO pair
//   clk   rising-edge clock
//   rst   asynchronous active-low reset
//   bus   muldiv_seq_if.slave: start/op/operands, MTHI/MTLO writes, hi/lo, busy/done/div_zero
module muldiv_seq
   import muldiv_pkg::*;
(
   input logic clk,
   input logic rst,
   muldiv_seq_if.slave bus
);
   state_t state, state_nx;
   logic [CW-1:0] cnt;
   logic [XLEN-1:0] acc_hi, acc_lo, b_reg, nx_hi, nx_lo, hi, lo, r_fix;
   logic [2*XLEN-1:0] prod_fix;
   logic is_div, neg_q, neg_r, dz, done, div_zero, sgn;

   muldiv_step u_step (
      .acc_hi(acc_hi),
      .acc_lo(acc_lo),
      .b(b_reg),
      .div(is_div),
      .nx_hi(nx_hi),
      .nx_lo(nx_lo)
   );

   always_comb begin
      state_nx = state;
      case (state)
         S_IDLE: state_nx = bus.start ? S_RUN : S_IDLE;
         S_RUN: state_nx = (cnt == '0) ? S_FIX : S_RUN;
         default: state_nx = S_IDLE;
      endcase
   end

   always_comb begin
      sgn = ~bus.op[0];
      // low half of the negated product is also the negated quotient
      prod_fix = neg_q ? -{acc_hi, acc_lo} : {acc_hi, acc_lo};
      r_fix = neg_r ? -acc_hi : acc_hi;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state <= S_IDLE;
         cnt <= '0;
         acc_hi <= '0;
         acc_lo <= '0;
         b_reg <= '0;
         is_div <= 1'b0;
         neg_q <= 1'b0;
         neg_r <= 1'b0;
         dz <= 1'b0;
         hi <= '0;
         lo <= '0;
         done <= 1'b0;
         div_zero <= 1'b0;
      end else begin
         state <= state_nx;
         done <= 1'b0;
         div_zero <= 1'b0;
         case (state)
            S_IDLE: begin
               if (bus.start) begin
                  acc_hi <= '0;
                  acc_lo <= sgn ? mag(bus.op_a) : bus.op_a;
                  b_reg <= sgn ? mag(bus.op_b) : bus.op_b;
                  is_div <= bus.op[1];
                  neg_q <= sgn & (bus.op_a[XLEN-1] ^ bus.op_b[XLEN-1]);
                  neg_r <= sgn & bus.op_a[XLEN-1];
                  dz <= bus.op[1] && (bus.op_b == '0);
                  cnt <= CW'(ITER - 1);
               end else begin
                  if (bus.mthi) hi <= bus.wr_data;
                  if (bus.mtlo) lo <= bus.wr_data;
               end
            end
            S_RUN: begin
               acc_hi <= nx_hi;
               acc_lo <= nx_lo;
               cnt <= cnt - 1'b1;
            end
            S_FIX: begin
               // a zero divisor leaves the dividend magnitude as remainder, so the sign fix restores op_a
               hi <= is_div ? r_fix : prod_fix[2*XLEN-1:XLEN];
               lo <= dz ? '1 : prod_fix[XLEN-1:0];
               done <= 1'b1;
               div_zero <= dz;
            end
            default: ;
         endcase
      end
   end

   assign bus.busy = (state != S_IDLE);
   assign bus.hi = hi;
   assign bus.lo = lo;
   assign bus.done = done;
   assign bus.div_zero = div_zero;
endmodule

// File: tb/tb_muldiv_seq.sv
// tb_muldiv_seq: directed and randomized checks of muldiv_seq against an arithmetic reference model
module tb_muldiv_seq;
   import muldiv_pkg::*;
   logic clk = 1'b0;
   logic rst = 1'b0;
   int checks = 0;
   int errors = 0;
   muldiv_seq_if bus ();
   muldiv_seq dut (.clk(clk), .rst(rst), .bus(bus));
   always #5 clk = ~clk;

   typedef struct {
      op_t op;
      logic [31:0] a, b, h, l;
      logic z;
   } vec_t;

   function automatic logic [64:0] model(input op_t op, input logic [31:0] a, input logic [31:0] b);
      longint sa, sb;
      int qa, qb;
      sa = $signed(a);
      sb = $signed(b);
      qa = a;
      qb = b;
      if (op == OP_MULT) return {1'b0, 64'(sa * sb)};
      if (op == OP_MULTU) return {1'b0, {32'b0, a} * {32'b0, b}};
      if (b == 0) return {1'b1, a, 32'hFFFF_FFFF};
      if (op == OP_DIVU) return {1'b0, a % b, a / b};
      if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {1'b0, 32'h0, 32'h8000_0000};
      return {1'b0, 32'(qa % qb), 32'(qa / qb)};
   endfunction

   // launch one op at a negedge and return at the negedge of the first non-busy cycle
   task automatic do_op(input op_t op, input logic [31:0] a, input logic [31:0] b, output int n,
                        output logic d, output logic z, output logic held, output logic [31:0] h, output logic [31:0] l);
      logic [31:0] h0, l0;
      h0 = bus.hi;
      l0 = bus.lo;
      held = 1'b1;
      bus.op = op;
      bus.op_a = a;
      bus.op_b = b;
      bus.start = 1'b1;
      @(negedge clk);
      bus.start = 1'b0;
      n = 0;
      while (bus.busy && n < 40) begin
         n++;
         if (bus.hi !== h0 || bus.lo !== l0) held = 1'b0;
         @(negedge clk);
      end
      d = bus.done;
      z = bus.div_zero;
      h = bus.hi;
      l = bus.lo;
   endtask

   task automatic test_reset();
      bus.start = 0; bus.op = OP_MULT; bus.op_a = 0; bus.op_b = 0;
      bus.mthi = 0; bus.mtlo = 0; bus.wr_data = 0;
      #1;
      checks++; if (bus.hi !== 32'h0) begin errors++; $display("FAIL reset_hi got %h exp 0", bus.hi); end
      checks++; if (bus.lo !== 32'h0) begin errors++; $display("FAIL reset_lo got %h exp 0", bus.lo); end
      checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b exp 0", bus.busy); end
      checks++; if (bus.done !== 1'b0) begin errors++; $display("FAIL reset_done got %b exp 0", bus.done); end
      checks++; if (bus.div_zero !== 1'b0) begin errors++; $display("FAIL reset_dz got %b exp 0", bus.div_zero); end
      repeat (2) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
   endtask

   task automatic test_directed();
      vec_t vt [8];
      int n;
      logic d, z, held;
      logic [31:0] h, l;
      vt[0] = '{OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 1'b0};
      vt[1] = '{OP_MULT, 32'hFFFF_FFFD, 32'd7, 32'hFFFF_FFFF, 32'hFFFF_FFEB, 1'b0};
      vt[2] = '{OP_MULT, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0, 1'b0};
      vt[3] = '{OP_DIV, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0};
      vt[4] = '{OP_DIVU, 32'd100, 32'd7, 32'd2, 32'd14, 1'b0};
      vt[5] = '{OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 32'h8000_0000, 1'b0};
      vt[6] = '{OP_DIVU, 32'h1234, 32'h0, 32'h1234, 32'hFFFF_FFFF, 1'b1};
      vt[7] = '{OP_DIV, 32'hFFFF_FFF9, 32'h0, 32'hFFFF_FFF9, 32'hFFFF_FFFF, 1'b1};
      for (int i = 0; i < 8; i++) begin
         do_op(vt[i].op, vt[i].a, vt[i].b, n, d, z, held, h, l);
         checks++; if (n !== 33) begin errors++; $display("FAIL dir%0d_busy_cycles got %0d exp 33", i, n); end
         checks++; if (d !== 1'b1) begin errors++; $display("FAIL dir%0d_done got %b exp 1", i, d); end
         checks++; if (held !== 1'b1) begin errors++; $display("FAIL dir%0d_hold got %b exp 1", i, held); end
         checks++; if (h !== vt[i].h) begin errors++; $display("FAIL dir%0d_hi got %h exp %h", i, h, vt[i].h); end
         checks++; if (l !== vt[i].l) begin errors++; $display("FAIL dir%0d_lo got %h exp %h", i, l, vt[i].l); end
         checks++; if (z !== vt[i].z) begin errors++; $display("FAIL dir%0d_div_zero got %b exp %b", i, z, vt[i].z); end
         @(negedge clk);
         checks++; if (bus.done !== 1'b0 || bus.div_zero !== 1'b0) begin
            errors++; $display("FAIL dir%0d_pulse got done=%b dz=%b exp 0 0", i, bus.done, bus.div_zero); end
      end
   endtask

   task automatic test_mt();
      bus.wr_data = 32'hAAAA_0000; bus.mthi = 1;
      @(negedge clk); bus.mthi = 0;
      checks++; if (bus.hi !== 32'hAAAA_0000) begin errors++; $display("FAIL mthi got %h exp aaaa0000", bus.hi); end
      bus.wr_data = 32'h5555; bus.mtlo = 1;
      @(negedge clk); bus.mtlo = 0;
      checks++; if (bus.lo !== 32'h5555 || bus.hi !== 32'hAAAA_0000) begin
         errors++; $display("FAIL mtlo got hi=%h lo=%h exp aaaa0000 00005555", bus.hi, bus.lo); end
      bus.wr_data = 32'h1357; bus.mthi = 1; bus.mtlo = 1;
      @(negedge clk); bus.mthi = 0; bus.mtlo = 0;
      checks++; if (bus.hi !== 32'h1357 || bus.lo !== 32'h1357) begin
         errors++; $display("FAIL mt_both got hi=%h lo=%h exp 1357 1357", bus.hi, bus.lo); end
      // start with mthi in the same cycle: the write must be dropped
      bus.wr_data = 32'hDEAD; bus.mthi = 1;
      bus.op = OP_MULTU; bus.op_a = 32'h1_0000; bus.op_b = 32'h3_0000; bus.start = 1;
      @(negedge clk); bus.mthi = 0; bus.start = 0;
      checks++; if (bus.hi !== 32'h1357 || bus.busy !== 1'b1) begin
         errors++; $display("FAIL start_wins got hi=%h busy=%b exp 1357 1", bus.hi, bus.busy); end
      for (int i = 0; i < 40 && bus.busy; i++) @(negedge clk);
      checks++; if (bus.hi !== 32'h3 || bus.lo !== 32'h0) begin
         errors++; $display("FAIL start_wins_result got hi=%h lo=%h exp 3 0", bus.hi, bus.lo); end
   endtask

   task automatic test_busy_ignore();
      int n;
      bus.op = OP_DIVU; bus.op_a = 32'd1000; bus.op_b = 32'd10; bus.start = 1;
      @(negedge clk); bus.start = 0;
      repeat (4) @(negedge clk);
      bus.wr_data = 32'hFFFF; bus.mthi = 1;
      bus.op = OP_MULT; bus.op_a = 2; bus.op_b = 2; bus.start = 1;
      @(negedge clk); bus.mthi = 0; bus.start = 0;
      checks++; if (bus.hi !== 32'h3) begin errors++; $display("FAIL busy_mthi got hi=%h exp 3", bus.hi); end
      n = 6;
      while (bus.busy && n < 40) begin n++; @(negedge clk); end
      checks++; if (n !== 34) begin errors++; $display("FAIL busy_ignore_latency got %0d exp 34", n); end
      checks++; if (bus.lo !== 32'd100 || bus.hi !== 32'd0) begin
         errors++; $display("FAIL busy_ignore_result got hi=%h lo=%h exp 0 64", bus.hi, bus.lo); end
      @(negedge clk);
      checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL busy_restart got busy=%b exp 0", bus.busy); end
   endtask

   task automatic test_reset_mid();
      int n;
      logic d, z, held;
      logic [31:0] h, l;
      bus.op = OP_MULTU; bus.op_a = 32'hFFFF; bus.op_b = 32'hFFFF; bus.start = 1;
      @(negedge clk); bus.start = 0;
      repeat (9) @(negedge clk);
      rst = 1'b0;
      #1;
      checks++; if (bus.busy !== 1'b0 || bus.hi !== 32'h0 || bus.lo !== 32'h0) begin
         errors++; $display("FAIL reset_mid got busy=%b hi=%h lo=%h exp 0 0 0", bus.busy, bus.hi, bus.lo); end
      @(negedge clk); rst = 1'b1;
      @(negedge clk);
      do_op(OP_MULTU, 32'd6, 32'd7, n, d, z, held, h, l);
      checks++; if (n !== 33 || d !== 1'b1 || l !== 32'd42 || h !== 32'd0) begin
         errors++; $display("FAIL after_reset got cycles=%0d done=%b hi=%h lo=%h exp 33 1 0 2a", n, d, h, l); end
   endtask

   // back-to-back random ops: each launch happens in the cycle the previous one reports done
   task automatic test_back_to_back();
      int n;
      logic d, z, held;
      logic [31:0] a, b, h, l;
      logic [64:0] exp;
      op_t op;
      for (int i = 0; i < 24; i++) begin
         op = op_t'($urandom_range(0, 3));
         a = ($urandom_range(0, 5) == 0) ? 32'h8000_0000 : $urandom;
         case ($urandom_range(0, 4))
            0: b = 32'h0;
            1: b = $urandom_range(1, 20);
            2: b = 32'hFFFF_FFFF;
            default: b = $urandom;
         endcase
         exp = model(op, a, b);
         do_op(op, a, b, n, d, z, held, h, l);
         checks++; if (n !== 33 || d !== 1'b1) begin
            errors++; $display("FAIL rnd%0d_timing got cycles=%0d done=%b exp 33 1", i, n, d); end
         checks++; if (h !== exp[63:32] || l !== exp[31:0] || z !== exp[64]) begin
            errors++; $display("FAIL rnd%0d op=%0d a=%h b=%h got hi=%h lo=%h dz=%b exp hi=%h lo=%h dz=%b",
                               i, op, a, b, h, l, z, exp[63:32], exp[31:0], exp[64]); end
      end
   endtask

   initial begin
      test_reset();
      test_directed();
      test_mt();
      test_busy_ignore();
      test_reset_mid();
      test_back_to_back();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
